// File: rtl/sprite_mover.sv
// Per-frame sprite physics: moves each sprite by its velocity, adds gravity, bounces off the screen edges,
// and publishes every coordinate in a single cycle once the pass is complete.
module sprite_mover #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned H_ACTIVE    = 1600,
  parameter int unsigned V_ACTIVE    = 1200,
  parameter int          GRAVITY     = 1,
  parameter logic [NUM_SPRITES-1:0][10:0] INIT_ROW = {11'd1000, 11'd900, 11'd500, 11'd400},
  parameter logic [NUM_SPRITES-1:0][11:0] INIT_COL = {12'd1500, 12'd1300, 12'd600, 12'd400},
  parameter logic [NUM_SPRITES-1:0][7:0]  INIT_VX  = {8'hFC, 8'h05, 8'hFE, 8'h03},
  parameter logic [NUM_SPRITES-1:0][7:0]  INIT_VY  = {8'h01, 8'hFD, 8'h02, 8'h00}
) (
  input  logic                             clock_162,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic                             run,
  input  logic [5:0]                       radius,
  output logic [NUM_SPRITES-1:0][10:0]     sprite_row,
  output logic [NUM_SPRITES-1:0][11:0]     sprite_col,
  output logic                             busy,
  output logic                             update_done
);

  localparam int unsigned IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned PW    = 14;
  localparam logic signed [PW-1:0] X_MAX = PW'(H_ACTIVE - 1);
  localparam logic signed [PW-1:0] Y_MAX = PW'(V_ACTIVE - 1);
  localparam logic signed [8:0]    V_POS = 9'sd127;
  localparam logic signed [8:0]    V_NEG = -9'sd127;

  typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, COMMIT} state_t;

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic [5:0]                     r;
  logic [NUM_SPRITES-1:0][10:0]   row;
  logic [NUM_SPRITES-1:0][11:0]   col;
  logic [NUM_SPRITES-1:0][7:0]    vx;
  logic [NUM_SPRITES-1:0][7:0]    vy;

  logic signed [PW-1:0] r_s, x_p, x_hi, y_p, y_hi;
  logic signed [8:0]    v_sum;
  logic signed [7:0]    v_sat;

  // Candidate positions for the sprite currently selected by idx
  always_comb begin
    r_s   = PW'($signed({1'b0, r}));
    x_p   = PW'($signed({1'b0, col[idx]})) + PW'($signed(vx[idx]));
    x_hi  = X_MAX - r_s;
    v_sum = 9'($signed(vy[idx])) + 9'(GRAVITY);
    if (v_sum > V_POS)      v_sat = 8'sd127;
    else if (v_sum < V_NEG) v_sat = -8'sd127;
    else                    v_sat = v_sum[7:0];
    y_p   = PW'($signed({1'b0, row[idx]})) + PW'(v_sat);
    y_hi  = Y_MAX - r_s;
  end

  always_ff @(posedge clock_162) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      r           <= '0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        row[i]        <= INIT_ROW[i];
        col[i]        <= INIT_COL[i];
        vx[i]         <= INIT_VX[i];
        vy[i]         <= INIT_VY[i];
        sprite_row[i] <= INIT_ROW[i];
        sprite_col[i] <= INIT_COL[i];
      end
    end else begin
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start && run) begin
            r     <= radius;
            idx   <= '0;
            busy  <= 1'b1;
            state <= UPD_X;
          end
        end
        UPD_X: begin
          if (x_p < r_s) begin
            col[idx] <= 12'(r_s);
            vx[idx]  <= -vx[idx];
          end else if (x_p > x_hi) begin
            col[idx] <= 12'(x_hi);
            vx[idx]  <= -vx[idx];
          end else begin
            col[idx] <= 12'(x_p);
          end
          state <= UPD_Y;
        end
        UPD_Y: begin
          if (y_p < r_s) begin
            row[idx] <= 11'(r_s);
            vy[idx]  <= -v_sat;
          end else if (y_p > y_hi) begin
            row[idx] <= 11'(y_hi);
            vy[idx]  <= -v_sat;
          end else begin
            row[idx] <= 11'(y_p);
            vy[idx]  <= v_sat;
          end
          if (idx == IDX_W'(NUM_SPRITES - 1)) begin
            state <= COMMIT;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= UPD_X;
          end
        end
        COMMIT: begin
          sprite_row  <= row;
          sprite_col  <= col;
          update_done <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: three instances (default, right-wall, floor) share the control inputs.
module tb_sprite_mover;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, frame_start, run;
  logic [5:0] radius_a, radius_b, radius_c;
  logic [N-1:0][10:0] row_a, row_b, row_c;
  logic [N-1:0][11:0] col_a, col_b, col_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;

  sprite_mover dut_a (.clock_162(clk), .rst(rst), .frame_start(frame_start), .run(run),
    .radius(radius_a), .sprite_row(row_a), .sprite_col(col_a), .busy(busy_a), .update_done(done_a));

  sprite_mover #(.INIT_COL({12'd1500, 12'd1300, 12'd600, 12'd1575}),
                 .INIT_VX({8'hFC, 8'h05, 8'hFE, 8'h05}))
    dut_b (.clock_162(clk), .rst(rst), .frame_start(frame_start), .run(run),
    .radius(radius_b), .sprite_row(row_b), .sprite_col(col_b), .busy(busy_b), .update_done(done_b));

  sprite_mover #(.INIT_ROW({11'd1000, 11'd900, 11'd500, 11'd1190}),
                 .INIT_VY({8'h01, 8'hFD, 8'h02, 8'd126}))
    dut_c (.clock_162(clk), .rst(rst), .frame_start(frame_start), .run(run),
    .radius(radius_c), .sprite_row(row_c), .sprite_col(col_c), .busy(busy_c), .update_done(done_c));

  int init_row [3][4] = '{'{400, 500, 900, 1000}, '{400, 500, 900, 1000}, '{1190, 500, 900, 1000}};
  int init_col [3][4] = '{'{400, 600, 1300, 1500}, '{1575, 600, 1300, 1500}, '{400, 600, 1300, 1500}};
  int init_vx  [3][4] = '{'{3, -2, 5, -4}, '{5, -2, 5, -4}, '{3, -2, 5, -4}};
  int init_vy  [3][4] = '{'{0, 2, -3, 1}, '{0, 2, -3, 1}, '{126, 2, -3, 1}};
  int m_row [3][4];
  int m_col [3][4];
  int m_vx  [3][4];
  int m_vy  [3][4];

  typedef struct { int inst; int idx; int row; int col; } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int passes = 0;

  function automatic int get_row(input int inst, input int i);
    case (inst)
      0:       return int'(row_a[i]);
      1:       return int'(row_b[i]);
      default: return int'(row_c[i]);
    endcase
  endfunction

  function automatic int get_col(input int inst, input int i);
    case (inst)
      0:       return int'(col_a[i]);
      1:       return int'(col_b[i]);
      default: return int'(col_c[i]);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) begin
        m_row[k][i] = init_row[k][i]; m_col[k][i] = init_col[k][i];
        m_vx[k][i]  = init_vx[k][i];  m_vy[k][i]  = init_vy[k][i];
      end
  endtask

  // Reference physics for one frame across all three instances
  task automatic model_frame();
    int r, p, v, hi;
    for (int k = 0; k < 3; k++) begin
      r = (k == 0) ? int'(radius_a) : (k == 1) ? int'(radius_b) : int'(radius_c);
      for (int i = 0; i < N; i++) begin
        p = m_col[k][i] + m_vx[k][i]; hi = 1599 - r;
        if (p < r)       begin m_col[k][i] = r;  m_vx[k][i] = -m_vx[k][i]; end
        else if (p > hi) begin m_col[k][i] = hi; m_vx[k][i] = -m_vx[k][i]; end
        else m_col[k][i] = p;
        v = m_vy[k][i] + 1;
        if (v > 127) v = 127;
        if (v < -127) v = -127;
        p = m_row[k][i] + v; hi = 1199 - r;
        if (p < r)       begin m_row[k][i] = r;  m_vy[k][i] = -v; end
        else if (p > hi) begin m_row[k][i] = hi; m_vy[k][i] = -v; end
        else begin m_row[k][i] = p; m_vy[k][i] = v; end
      end
    end
  endtask

  task automatic push_expected();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) sb.push_back('{k, i, m_row[k][i], m_col[k][i]});
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    sb.delete();
  endtask

  // Pulses frame_start so that it is sampled by the next edge (edge 0); returns #1 after edge 0
  task automatic pulse_start(input bit accepted);
    @(posedge clk); #1 frame_start = 1'b1;
    if (accepted) begin model_frame(); push_expected(); end
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    push_expected();
    checks++;
    if (row_a !== {11'd1000, 11'd900, 11'd500, 11'd400} || col_a !== {12'd1500, 12'd1300, 12'd600, 12'd400}) $display("FAIL reset_coords: got row %h col %h", row_a, col_a);
    else passes++;
    checks++;
    if ({busy_a, busy_b, busy_c, done_a, done_b, done_c} !== 6'b0) $display("FAIL reset_flags: got busy %b%b%b done %b%b%b, want 0", busy_a, busy_b, busy_c, done_a, done_b, done_c);
    else passes++;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (get_row(e.inst, e.idx) !== e.row || get_col(e.inst, e.idx) !== e.col) $display("FAIL reset_sb inst%0d spr%0d: got %0d,%0d want %0d,%0d", e.inst, e.idx, get_row(e.inst, e.idx), get_col(e.inst, e.idx), e.row, e.col);
      else passes++;
    end
  endtask

  task automatic test_single_frame(input bit reset_first);
    logic [N-1:0][10:0] pre_row;
    logic [N-1:0][11:0] pre_col;
    int busy_cnt, done_edge, changed;
    if (reset_first) do_reset();
    radius_a = 6'd10; run = 1'b1;
    pre_row = row_a; pre_col = col_a;
    pulse_start(1'b1);
    busy_cnt = busy_a ? 1 : 0; done_edge = 0; changed = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done_a) begin done_edge = k; break; end
      if (busy_a) busy_cnt++;
      if (row_a !== pre_row || col_a !== pre_col) changed = 1;
    end
    checks++;
    if (done_edge !== 9) $display("FAIL single_done_edge: got %0d, want 9", done_edge); else passes++;
    checks++;
    if (busy_cnt !== 9 || busy_a !== 1'b0) $display("FAIL single_busy: got %0d cycles (busy now %b), want 9 and 0", busy_cnt, busy_a); else passes++;
    checks++;
    if (changed !== 0) $display("FAIL single_early_change: outputs moved before update_done"); else passes++;
    checks++;
    if (row_a[0] !== 11'd401 || col_a[0] !== 12'd403 || row_a[1] !== 11'd503 || col_a[1] !== 12'd598)
      $display("FAIL single_values: got s0 %0d,%0d s1 %0d,%0d want 401,403 503,598", row_a[0], col_a[0], row_a[1], col_a[1]);
    else passes++;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (get_row(e.inst, e.idx) !== e.row || get_col(e.inst, e.idx) !== e.col) $display("FAIL single_sb inst%0d spr%0d: got %0d,%0d want %0d,%0d", e.inst, e.idx, get_row(e.inst, e.idx), get_col(e.inst, e.idx), e.row, e.col);
      else passes++;
    end
    @(posedge clk); #1;
    checks++;
    if (done_a !== 1'b0) $display("FAIL single_done_width: got %b one cycle later, want 0", done_a); else passes++;
  endtask

  task automatic test_bounce();
    int got;
    do_reset();
    radius_a = 6'd10; run = 1'b1;
    for (int f = 1; f <= 2; f++) begin
      pulse_start(1'b1);
      got = 0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (done_a) begin got = 1; break; end
      end
      checks++;
      if (got !== 1 || done_b !== 1'b1 || done_c !== 1'b1) $display("FAIL bounce_done f%0d: got %0d %b %b, want 1 1 1", f, got, done_b, done_c); else passes++;
      checks++;
      if (f == 1 && (col_b[0] !== 12'd1579 || row_c[0] !== 11'd1194)) $display("FAIL bounce_f1: got col %0d row %0d, want 1579 1194", col_b[0], row_c[0]);
      else if (f == 2 && (col_b[0] !== 12'd1574 || row_c[0] !== 11'd1068)) $display("FAIL bounce_f2: got col %0d row %0d, want 1574 1068", col_b[0], row_c[0]);
      else passes++;
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (get_row(e.inst, e.idx) !== e.row || get_col(e.inst, e.idx) !== e.col) $display("FAIL bounce_sb f%0d inst%0d spr%0d: got %0d,%0d want %0d,%0d", f, e.inst, e.idx, get_row(e.inst, e.idx), get_col(e.inst, e.idx), e.row, e.col);
        else passes++;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_ignored();
    logic [N-1:0][10:0] pre_row;
    logic [N-1:0][11:0] pre_col;
    int dones, busy_seen, changed;
    do_reset();
    radius_a = 6'd17; run = 1'b1;
    pulse_start(1'b1);
    dones = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (done_a) dones++;
      frame_start = (k == 3 || k == 5);
    end
    checks++;
    if (dones !== 1) $display("FAIL ignored_midpass: got %0d update_done pulses, want 1", dones); else passes++;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (get_row(e.inst, e.idx) !== e.row || get_col(e.inst, e.idx) !== e.col) $display("FAIL ignored_sb inst%0d spr%0d: got %0d,%0d want %0d,%0d", e.inst, e.idx, get_row(e.inst, e.idx), get_col(e.inst, e.idx), e.row, e.col);
      else passes++;
    end
    run = 1'b0; pre_row = row_a; pre_col = col_a;
    pulse_start(1'b0);
    busy_seen = busy_a; dones = 0; changed = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (busy_a) busy_seen = 1;
      if (done_a) dones++;
      if (row_a !== pre_row || col_a !== pre_col) changed = 1;
    end
    checks++;
    if (busy_seen !== 0 || dones !== 0 || changed !== 0) $display("FAIL ignored_run_low: got busy %0d done %0d changed %0d, want 0 0 0", busy_seen, dones, changed); else passes++;
    run = 1'b1;
  endtask

  task automatic test_reset_mid();
    int dones;
    do_reset();
    radius_a = 6'd10; run = 1'b1;
    pulse_start(1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL midreset_flags: got busy %b done %b, want 0 0", busy_a, done_a); else passes++;
    model_reset(); push_expected();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (get_row(e.inst, e.idx) !== e.row || get_col(e.inst, e.idx) !== e.col) $display("FAIL midreset_sb inst%0d spr%0d: got %0d,%0d want %0d,%0d", e.inst, e.idx, get_row(e.inst, e.idx), get_col(e.inst, e.idx), e.row, e.col);
      else passes++;
    end
    rst = 1'b0; dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) dones++;
    end
    checks++;
    if (dones !== 0) $display("FAIL midreset_no_done: got %0d active cycles after abort, want 0", dones); else passes++;
    test_single_frame(1'b0);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; run = 1'b0;
    radius_a = 6'd10; radius_b = 6'd20; radius_c = 6'd5;
    test_reset();
    test_single_frame(1'b1);
    test_bounce();
    test_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
